hdmi_island_scheduler: RTL and testbench

Schedules HDMI data-island packet slots inside horizontal blanking and arbitrates which packet source owns each slot. Packet sources are ACR, AVI infoframe, audio infoframe and audio samples. Sits between the timing generator and the HDMI data encoder. Tells the encoder when to emit a 32-clock packet and which packet mux input to use, and returns a one-cycle grant to the winning source.

---
 rtl/hdmi_island_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_hdmi_island_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_island_scheduler.sv
// HDMI data-island slot scheduler: places up to MAX_SLOTS packet slots inside each
// horizontal blanking window and arbitrates which packet source owns every slot.
module hdmi_island_scheduler #(
  parameter int SLOT_LEN     = 32,
  parameter int MAX_SLOTS    = 2,
  parameter int START_OFFSET = 0,
  parameter int STARVE_LINES = 4
) (
  input  logic                        i_pixclk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic                        i_hSync,
  input  logic                        i_blank,
  input  logic                        i_acr_req,
  input  logic                        i_avi_req,
  input  logic                        i_aif_req,
  input  logic                        i_aud_req,
  output logic                        o_active,
  output logic                        o_slot_start,
  output logic [1:0]                  o_slot_sel,
  output logic [3:0]                  o_grant,
  output logic [$clog2(SLOT_LEN)-1:0] o_slot_cnt,
  output logic                        o_last_slot,
  output logic                        o_abort,
  output logic [3:0]                  o_pending
);
  localparam int               CNT_W     = $clog2(SLOT_LEN);
  localparam logic [1:0]       SEL_ACR   = 2'd0;
  localparam logic [1:0]       SEL_AUD   = 2'd1;
  localparam logic [1:0]       SEL_AVI   = 2'd2;
  localparam logic [1:0]       SEL_AIF   = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_LEN - 1);
  localparam logic [7:0]       WAIT_LOAD = 8'((START_OFFSET > 0) ? START_OFFSET - 1 : 0);
  localparam logic [3:0]       STARVE_TH = 4'(STARVE_LINES);
  localparam logic [2:0]       SLOTS_MAX = 3'(MAX_SLOTS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARB, S_SLOT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_hs_p1;
  logic             r_hs_p2;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_slot_cnt;
  logic [1:0]       r_sel;
  logic [2:0]       r_nslot;
  logic             r_last;
  logic             r_acr_pend;
  logic             r_avi_pend;
  logic             r_aif_pend;
  logic [3:0]       r_avi_starve;
  logic [3:0]       r_aif_starve;

  logic             w_trig;
  logic [3:0]       w_pend_cur;
  logic             w_prom_avi;
  logic             w_prom_aif;
  logic             w_arb_vld;
  logic [1:0]       w_arb_sel;
  logic             w_in_slot;
  logic             w_start;
  logic             w_slot_end;
  logic             w_abort;
  logic             w_more;
  logic [3:0]       w_grant;
  logic             w_acr_nxt;
  logic             w_avi_nxt;
  logic             w_aif_nxt;
  logic             w_last_now;
  logic             w_win_end;

  // Fixed priority with starved infoframes promoted just below ACR.
  function automatic logic [1:0] f_arb(input logic [3:0] pend, input logic prom_avi,
                                       input logic prom_aif);
    logic [1:0] sel;
    sel = SEL_ACR;
    if (pend[0])                  sel = SEL_ACR;
    else if (pend[2] && prom_avi) sel = SEL_AVI;
    else if (pend[3] && prom_aif) sel = SEL_AIF;
    else if (pend[1])             sel = SEL_AUD;
    else if (pend[2])             sel = SEL_AVI;
    else if (pend[3])             sel = SEL_AIF;
    return sel;
  endfunction

  assign w_trig     = r_hs_p1 & ~r_hs_p2 & i_blank & i_enable;
  assign w_pend_cur = {r_aif_pend, r_avi_pend, i_aud_req, r_acr_pend};
  assign w_prom_avi = (r_avi_starve >= STARVE_TH);
  assign w_prom_aif = (r_aif_starve >= STARVE_TH);
  assign w_arb_vld  = |w_pend_cur;
  assign w_arb_sel  = f_arb(w_pend_cur, w_prom_avi, w_prom_aif);

  assign w_in_slot  = (r_state == S_SLOT);
  assign w_start    = w_in_slot && (r_slot_cnt == '0);
  assign w_slot_end = w_in_slot && (r_slot_cnt == CNT_LAST);
  assign w_abort    = w_in_slot && !i_blank;
  assign w_more     = (r_nslot < SLOTS_MAX) && i_enable && w_arb_vld;
  assign w_grant    = w_start ? (4'b0001 << r_sel) : 4'b0000;

  // A request arriving in the grant cycle survives the clear.
  assign w_acr_nxt  = (r_acr_pend & ~w_grant[0]) | i_acr_req;
  assign w_avi_nxt  = (r_avi_pend & ~w_grant[2]) | i_avi_req;
  assign w_aif_nxt  = (r_aif_pend & ~w_grant[3]) | i_aif_req;

  // Last-slot prediction looks at what would still be waiting once this grant lands.
  assign w_last_now = (r_nslot >= SLOTS_MAX) || !(w_acr_nxt || w_avi_nxt || w_aif_nxt || i_aud_req);
  assign w_win_end  = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_trig) w_state_nxt = (START_OFFSET == 0) ? S_ARB : S_WAIT;
      end
      S_WAIT: begin
        if (!i_blank)                 w_state_nxt = S_IDLE;
        else if (r_wait_cnt == 8'd0)  w_state_nxt = S_ARB;
      end
      S_ARB: begin
        w_state_nxt = w_arb_vld ? S_SLOT : S_IDLE;
      end
      S_SLOT: begin
        if (w_abort)         w_state_nxt = S_IDLE;
        else if (w_slot_end) w_state_nxt = w_more ? S_SLOT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_active     = 1'b0;
    o_slot_start = 1'b0;
    o_slot_sel   = 2'd0;
    o_grant      = 4'b0000;
    o_slot_cnt   = '0;
    o_last_slot  = 1'b0;
    o_abort      = 1'b0;
    o_pending    = {r_aif_pend, r_avi_pend, i_aud_req, r_acr_pend};
    if (w_in_slot) begin
      o_active     = 1'b1;
      o_slot_start = w_start;
      o_slot_sel   = r_sel;
      o_grant      = w_grant;
      o_slot_cnt   = r_slot_cnt;
      o_last_slot  = w_start ? w_last_now : r_last;
      o_abort      = w_abort;
    end
  end

  always_ff @(posedge i_pixclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs_p1      <= 1'b0;
      r_hs_p2      <= 1'b0;
      r_wait_cnt   <= 8'd0;
      r_slot_cnt   <= '0;
      r_sel        <= 2'd0;
      r_nslot      <= 3'd0;
      r_last       <= 1'b0;
      r_acr_pend   <= 1'b0;
      r_avi_pend   <= 1'b0;
      r_aif_pend   <= 1'b0;
      r_avi_starve <= 4'd0;
      r_aif_starve <= 4'd0;
    end else begin
      r_hs_p1    <= i_hSync;
      r_hs_p2    <= r_hs_p1;
      r_acr_pend <= w_acr_nxt;
      r_avi_pend <= w_avi_nxt;
      r_aif_pend <= w_aif_nxt;

      if (r_state == S_IDLE)      r_wait_cnt <= WAIT_LOAD;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt - 8'd1;

      if (w_in_slot && !w_slot_end && !w_abort) r_slot_cnt <= r_slot_cnt + CNT_W'(1);
      else                                      r_slot_cnt <= '0;

      if ((r_state == S_ARB) || w_slot_end) r_sel <= w_arb_sel;

      if (r_state == S_ARB)          r_nslot <= 3'd1;
      else if (w_slot_end && w_more) r_nslot <= r_nslot + 3'd1;

      if (w_start) r_last <= w_last_now;

      // Starvation ages once per window that ends with the infoframe still waiting.
      if (w_grant[2] || !r_avi_pend)              r_avi_starve <= 4'd0;
      else if (w_win_end && r_avi_starve != 4'hF) r_avi_starve <= r_avi_starve + 4'd1;

      if (w_grant[3] || !r_aif_pend)              r_aif_starve <= 4'd0;
      else if (w_win_end && r_aif_starve != 4'hF) r_aif_starve <= r_aif_starve + 4'd1;
    end
  end
endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Bench for hdmi_island_scheduler: two differently parameterised instances share
// stimulus and are compared every cycle against a window-level behavioural model.
module tb_hdmi_island_scheduler;
  logic clk = 1'b0;
  logic rst_n, en, hs, blank, acr, avi, aif, aud;
  logic act0, st0, last0, ab0;
  logic [1:0] sel0;
  logic [3:0] gr0, pd0;
  logic [4:0] cnt0;
  logic act1, st1, last1, ab1;
  logic [1:0] sel1;
  logic [3:0] gr1, pd1;
  logic [3:0] cnt1;

  always #5 clk = ~clk;

  hdmi_island_scheduler u_dut0 (
    .i_pixclk(clk), .i_rst_n(rst_n), .i_enable(en), .i_hSync(hs), .i_blank(blank),
    .i_acr_req(acr), .i_avi_req(avi), .i_aif_req(aif), .i_aud_req(aud),
    .o_active(act0), .o_slot_start(st0), .o_slot_sel(sel0), .o_grant(gr0),
    .o_slot_cnt(cnt0), .o_last_slot(last0), .o_abort(ab0), .o_pending(pd0));

  hdmi_island_scheduler #(.SLOT_LEN(16), .MAX_SLOTS(3), .START_OFFSET(8), .STARVE_LINES(2)) u_dut1 (
    .i_pixclk(clk), .i_rst_n(rst_n), .i_enable(en), .i_hSync(hs), .i_blank(blank),
    .i_acr_req(acr), .i_avi_req(avi), .i_aif_req(aif), .i_aud_req(aud),
    .o_active(act1), .o_slot_start(st1), .o_slot_sel(sel1), .o_grant(gr1),
    .o_slot_cnt(cnt1), .o_last_slot(last1), .o_abort(ab1), .o_pending(pd1));

  localparam int P_SL[2] = '{32, 16};
  localparam int P_MS[2] = '{2, 3};
  localparam int P_SO[2] = '{0, 8};
  localparam int P_SV[2] = '{4, 2};

  // Model: phase 0 idle, 1 offset wait, 2 arbitration, 3 inside a slot.
  int m_ph[2], m_wait[2], m_pos[2], m_src[2], m_used[2];
  bit m_last[2], m_hq1[2], m_hq2[2];
  bit m_pend[2][4];
  int m_starve[2][4];

  int n_tests = 0, n_fail = 0;
  int s_act, s_start, s_abort, s_first_sel;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int k);
    if (m_pend[k][0]) return 0;
    if (m_pend[k][2] && m_starve[k][2] >= P_SV[k]) return 2;
    if (m_pend[k][3] && m_starve[k][3] >= P_SV[k]) return 3;
    if (aud) return 1;
    if (m_pend[k][2]) return 2;
    if (m_pend[k][3]) return 3;
    return -1;
  endfunction

  task automatic model_reset(input int k);
    m_ph[k] = 0; m_wait[k] = 0; m_pos[k] = 0; m_src[k] = 0; m_used[k] = 0;
    m_last[k] = 0; m_hq1[k] = 0; m_hq2[k] = 0;
    for (int i = 0; i < 4; i++) begin m_pend[k][i] = 0; m_starve[k][i] = 0; end
  endtask

  task automatic check_step(input int k);
    logic [31:0] g_act, g_st, g_sel, g_gr, g_cnt, g_last, g_ab, g_pd;
    bit in_slot, first, fin, any_left;
    bit req[4];
    logic [3:0] eg;
    int w;
    g_act = (k == 0) ? 32'(act0) : 32'(act1);
    g_st = (k == 0) ? 32'(st0) : 32'(st1);
    g_sel = (k == 0) ? 32'(sel0) : 32'(sel1);
    g_gr = (k == 0) ? 32'(gr0) : 32'(gr1);
    g_cnt = (k == 0) ? 32'(cnt0) : 32'(cnt1);
    g_last = (k == 0) ? 32'(last0) : 32'(last1);
    g_ab = (k == 0) ? 32'(ab0) : 32'(ab1);
    g_pd = (k == 0) ? 32'(pd0) : 32'(pd1);
    if (!rst_n) model_reset(k);
    req[0] = acr; req[1] = 1'b0; req[2] = avi; req[3] = aif;
    in_slot = rst_n && (m_ph[k] == 3);
    first = in_slot && (m_pos[k] == 0);
    eg = first ? (4'b0001 << m_src[k]) : 4'b0000;
    if (first) begin
      any_left = aud;
      for (int i = 0; i < 4; i++)
        if (i != 1 && ((m_pend[k][i] && !eg[i]) || req[i])) any_left = 1;
      m_last[k] = (m_used[k] >= P_MS[k]) || !any_left;
    end
    check_val($sformatf("u%0d_active", k), g_act, 32'(in_slot));
    check_val($sformatf("u%0d_slot_start", k), g_st, 32'(first));
    check_val($sformatf("u%0d_slot_sel", k), g_sel, in_slot ? 32'(m_src[k]) : 0);
    check_val($sformatf("u%0d_grant", k), g_gr, 32'(eg));
    check_val($sformatf("u%0d_slot_cnt", k), g_cnt, in_slot ? 32'(m_pos[k]) : 0);
    check_val($sformatf("u%0d_last_slot", k), g_last, 32'(in_slot && m_last[k]));
    check_val($sformatf("u%0d_abort", k), g_ab, 32'(in_slot && !blank));
    check_val($sformatf("u%0d_pending", k), g_pd,
              32'({m_pend[k][3], m_pend[k][2], aud, m_pend[k][0]}));
    if (!rst_n) return;
    fin = 0;
    case (m_ph[k])
      0: if (m_hq1[k] && !m_hq2[k] && blank && en) begin
           if (P_SO[k] == 0) m_ph[k] = 2;
           else begin m_ph[k] = 1; m_wait[k] = P_SO[k]; end
         end
      1: if (!blank) begin m_ph[k] = 0; fin = 1; end
         else begin
           m_wait[k]--;
           if (m_wait[k] == 0) m_ph[k] = 2;
         end
      2: begin
           w = pick(k);
           if (w < 0) begin m_ph[k] = 0; fin = 1; end
           else begin m_ph[k] = 3; m_src[k] = w; m_pos[k] = 0; m_used[k] = 1; end
         end
      default: begin
        if (!blank) begin m_ph[k] = 0; fin = 1; end
        else if (m_pos[k] == P_SL[k] - 1) begin
          w = pick(k);
          if (m_used[k] < P_MS[k] && en && w >= 0) begin
            m_src[k] = w; m_pos[k] = 0; m_used[k]++;
          end else begin m_ph[k] = 0; fin = 1; end
        end else m_pos[k]++;
      end
    endcase
    for (int i = 2; i < 4; i++) begin
      if (eg[i] || !m_pend[k][i]) m_starve[k][i] = 0;
      else if (fin && m_starve[k][i] < 15) m_starve[k][i]++;
    end
    for (int i = 0; i < 4; i++)
      if (i != 1) m_pend[k][i] = (m_pend[k][i] && !eg[i]) || req[i];
    m_hq2[k] = m_hq1[k];
    m_hq1[k] = hs;
  endtask

  task automatic tick();
    @(negedge clk);
    check_step(0);
    check_step(1);
    if (act0) s_act++;
    if (ab0) s_abort++;
    if (st0) begin
      s_start++;
      if (s_start == 1) s_first_sel = int'(sel0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit a, input bit v, input bit f);
    acr = a; avi = v; aif = f;
    tick();
    acr = 0; avi = 0; aif = 0;
  endtask

  // mode: 0 plain, 1 re-request AVI at its grant, 2 blank drop at cnt 10, 3 reset mid-slot, 4 enable drop
  task automatic run_line(input int n_blank, input int hs_at, input int hs_len, input int n_act,
                          input int p_req, input int mode, input int drop_at);
    bit cut, rst_done;
    int rst_hold;
    cut = 0; rst_done = 0; rst_hold = 0;
    s_act = 0; s_start = 0; s_abort = 0; s_first_sel = -1;
    for (int c = 0; c < n_blank + n_act; c++) begin
      if (mode == 3 && !rst_done && act0 && cnt0 == 5'd5) begin
        rst_done = 1;
        #1 rst_n = 0;
        #1;
        check_val("rst_mid_active0", 32'(act0), 0);
        check_val("rst_mid_start0", 32'(st0), 0);
        check_val("rst_mid_grant0", 32'(gr0), 0);
        check_val("rst_mid_cnt0", 32'(cnt0), 0);
        check_val("rst_mid_sel0", 32'(sel0), 0);
        check_val("rst_mid_last0", 32'(last0), 0);
        check_val("rst_mid_pend0", 32'(pd0), 32'({2'b00, aud, 1'b0}));
        check_val("rst_mid_active1", 32'(act1), 0);
        rst_hold = 3;
      end
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1;
      end
      if (mode == 2 && !cut && act0 && cnt0 == 5'd10 && s_start == 1) cut = 1;
      blank = (c < n_blank) && !cut;
      hs = (c >= hs_at) && (c < hs_at + hs_len);
      acr = ($urandom_range(99) < p_req);
      avi = ($urandom_range(99) < p_req);
      aif = ($urandom_range(99) < p_req);
      if (mode == 1 && st0 && sel0 == 2'd2) avi = 1;
      if (mode == 4 && c == drop_at) en = 0;
      tick();
    end
    acr = 0; avi = 0; aif = 0; hs = 0; en = 1;
  endtask

  initial begin
    int sel_line[5];
    rst_n = 0; en = 0; hs = 0; blank = 0; acr = 0; avi = 0; aif = 0; aud = 0;
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    #1;
    tick();
    tick();
    check_val("reset_active", 32'(act0), 0);
    check_val("reset_grant", 32'(gr0), 0);
    check_val("reset_pending", 32'(pd0), 0);
    check_val("reset_cnt1", 32'(cnt1), 0);
    rst_n = 1; en = 1;
    tick();

    // ACR then AVI back to back, AVI slot flagged last
    pulse(1, 1, 0);
    run_line(100, 5, 4, 20, 0, 0, 0);
    check_val("t1_active_clocks", 32'(s_act), 64);
    check_val("t1_starts", 32'(s_start), 2);
    check_val("t1_first_sel", 32'(s_first_sel), 0);
    check_val("t1_pend_after", 32'(pd0), 0);

    // continuous audio starves AVI until promotion
    aud = 1;
    pulse(0, 1, 0);
    for (int l = 0; l < 5; l++) begin
      run_line(100, 3, 2, 20, 0, 0, 0);
      sel_line[l] = s_first_sel;
    end
    for (int l = 0; l < 4; l++) check_val($sformatf("t2_line%0d_sel", l + 1), 32'(sel_line[l]), 1);
    check_val("t2_line5_sel", 32'(sel_line[4]), 2);
    check_val("t2_avi_cleared", 32'(pd0[2]), 0);
    aud = 0;

    // nothing pending: no slot
    run_line(60, 4, 3, 10, 0, 0, 0);
    check_val("t3_no_active", 32'(s_act), 0);

    // AVI re-requested in its grant cycle stays pending and is served next line
    pulse(1, 1, 0);
    run_line(100, 2, 3, 20, 0, 1, 0);
    check_val("t4_starts", 32'(s_start), 2);
    check_val("t4_avi_still_pend", 32'(pd0[2]), 1);
    run_line(100, 2, 3, 20, 0, 0, 0);
    check_val("t4_next_line_sel", 32'(s_first_sel), 2);

    // blank falls mid-slot
    pulse(1, 1, 0);
    run_line(100, 2, 3, 20, 0, 2, 0);
    check_val("t5_abort_pulses", 32'(s_abort), 1);
    check_val("t5_single_slot", 32'(s_start), 1);
    check_val("t5_acr_consumed", 32'(pd0[0]), 0);
    check_val("t5_avi_kept", 32'(pd0[2]), 1);

    // reset mid-slot loses pending work
    pulse(1, 0, 0);
    run_line(100, 2, 3, 20, 0, 3, 0);
    pulse(1, 0, 0);
    run_line(100, 2, 3, 20, 0, 0, 0);
    check_val("t6_after_reset_starts", 32'(s_start), 1);
    check_val("t6_after_reset_sel", 32'(s_first_sel), 0);

    // randomised lines
    for (int l = 0; l < 30; l++) begin
      int md, ha;
      aud = ($urandom_range(99) < 40);
      md = ($urandom_range(3) == 0) ? 4 : 0;
      ha = $urandom_range(10, 1);
      run_line($urandom_range(110, 70), ha, $urandom_range(6, 1), $urandom_range(30, 5),
               $urandom_range(15), md, ha + $urandom_range(60));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
